// File: rtl/pattern_frame_gen.sv
// One frame of RGB565 test pattern per start pulse, raster order, one pixel per wr_en cycle.
// Latency 1 cycle wr_en -> data_en; wr_en low stalls the raster; start_i outside IDLE is dropped.
module pattern_frame_gen #(
  parameter int H_ACTIVE = 1024,
  parameter int V_ACTIVE = 768,
  parameter int BOX_SIZE = 64,
  parameter int BOX_STEP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [1:0]  mode_i,
  input  logic        wr_en,
  output logic        data_en,
  output logic [15:0] dout,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  frame_cnt
);

  localparam int XW  = $clog2(H_ACTIVE);
  localparam int YW  = $clog2(V_ACTIVE);
  localparam int BW  = $clog2(H_ACTIVE / 8);
  localparam int XW1 = XW + 1;
  localparam int YW1 = YW + 1;

  localparam logic [XW-1:0] X_LAST   = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_ACTIVE - 1);
  localparam logic [BW-1:0] BAR_LAST = BW'(H_ACTIVE / 8 - 1);

  localparam logic [XW:0] BOX_X  = XW1'(BOX_SIZE);
  localparam logic [XW:0] STEP_X = XW1'(BOX_STEP);
  localparam logic [XW:0] LIM_X  = XW1'(H_ACTIVE - BOX_SIZE);
  localparam logic [YW:0] BOX_Y  = YW1'(BOX_SIZE);
  localparam logic [YW:0] STEP_Y = YW1'(BOX_STEP);
  localparam logic [YW:0] LIM_Y  = YW1'(V_ACTIVE - BOX_SIZE);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      mode_q, mode_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [BW-1:0]   bar_px_q, bar_px_d;
  logic [2:0]      bar_idx_q, bar_idx_d;
  logic [4:0]      grad_b_q, grad_b_d;
  logic [XW-1:0]   bx_q, bx_d;
  logic [YW-1:0]   by_q, by_d;
  logic            dx_q, dx_d;
  logic            dy_q, dy_d;
  logic            data_en_q, data_en_d;
  logic [15:0]     dout_q, dout_d;
  logic            busy_q, busy_d;
  logic            frame_done_q, frame_done_d;
  logic [7:0]      frame_cnt_q, frame_cnt_d;

  logic [XW:0]     x_w, bx_w, bx_plus;
  logic [YW:0]     y_w, by_w, by_plus;
  logic            in_box;
  logic [15:0]     pix;

  assign x_w     = {1'b0, x_q};
  assign y_w     = {1'b0, y_q};
  assign bx_w    = {1'b0, bx_q};
  assign by_w    = {1'b0, by_q};
  assign bx_plus = bx_w + STEP_X;
  assign by_plus = by_w + STEP_Y;
  assign in_box  = (x_w >= bx_w) && (x_w < bx_w + BOX_X) &&
                   (y_w >= by_w) && (y_w < by_w + BOX_Y);

  always_comb begin
    pix = 16'h0000;
    case (mode_q)
      2'd0: begin
        case (bar_idx_q)
          3'd0:    pix = 16'hFFFF;
          3'd1:    pix = 16'hFFE0;
          3'd2:    pix = 16'h07FF;
          3'd3:    pix = 16'h07E0;
          3'd4:    pix = 16'hF81F;
          3'd5:    pix = 16'hF800;
          3'd6:    pix = 16'h001F;
          default: pix = 16'h0000;
        endcase
      end
      2'd1:    pix = (1'(x_q >> 5) ^ 1'(y_q >> 5)) ? 16'h0000 : 16'hFFFF;
      2'd2:    pix = {5'(x_q >> 3), 6'(y_q >> 2), grad_b_q};
      default: pix = in_box ? 16'hFFFF : 16'h001F;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    x_d          = x_q;
    y_d          = y_q;
    bar_px_d     = bar_px_q;
    bar_idx_d    = bar_idx_q;
    grad_b_d     = grad_b_q;
    bx_d         = bx_q;
    by_d         = by_q;
    dx_d         = dx_q;
    dy_d         = dy_q;
    data_en_d    = 1'b0;
    dout_d       = dout_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          mode_d    = mode_i;
          grad_b_d  = frame_cnt_q[4:0];
          x_d       = '0;
          y_d       = '0;
          bar_px_d  = '0;
          bar_idx_d = '0;
          busy_d    = 1'b1;
          state_d   = RUN;
        end
      end

      RUN: begin
        if (wr_en) begin
          data_en_d = 1'b1;
          dout_d    = pix;
          if (x_q == X_LAST) begin
            x_d       = '0;
            bar_px_d  = '0;
            bar_idx_d = '0;
            if (y_q == Y_LAST) begin
              y_d     = '0;
              state_d = DONE;
            end else begin
              y_d = y_q + YW'(1);
            end
          end else begin
            x_d = x_q + XW'(1);
            if (bar_px_q == BAR_LAST) begin
              bar_px_d  = '0;
              bar_idx_d = bar_idx_q + 3'd1;
            end else begin
              bar_px_d = bar_px_q + BW'(1);
            end
          end
        end
      end

      DONE: begin
        frame_done_d = 1'b1;
        busy_d       = 1'b0;
        frame_cnt_d  = frame_cnt_q + 8'd1;
        state_d      = IDLE;

        // Clamps only matter for degenerate BOX_SIZE/BOX_STEP combos; they keep the box on screen.
        if (dx_q) begin
          if (bx_plus > LIM_X) begin
            dx_d = 1'b0;
            bx_d = (bx_w >= STEP_X) ? XW'(bx_w - STEP_X) : '0;
          end else begin
            bx_d = XW'(bx_plus);
          end
        end else begin
          if (bx_w < STEP_X) begin
            dx_d = 1'b1;
            bx_d = (bx_plus > LIM_X) ? XW'(LIM_X) : XW'(bx_plus);
          end else begin
            bx_d = XW'(bx_w - STEP_X);
          end
        end

        if (dy_q) begin
          if (by_plus > LIM_Y) begin
            dy_d = 1'b0;
            by_d = (by_w >= STEP_Y) ? YW'(by_w - STEP_Y) : '0;
          end else begin
            by_d = YW'(by_plus);
          end
        end else begin
          if (by_w < STEP_Y) begin
            dy_d = 1'b1;
            by_d = (by_plus > LIM_Y) ? YW'(LIM_Y) : YW'(by_plus);
          end else begin
            by_d = YW'(by_w - STEP_Y);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mode_q       <= 2'd0;
      x_q          <= '0;
      y_q          <= '0;
      bar_px_q     <= '0;
      bar_idx_q    <= 3'd0;
      grad_b_q     <= 5'd0;
      bx_q         <= '0;
      by_q         <= '0;
      dx_q         <= 1'b1;
      dy_q         <= 1'b1;
      data_en_q    <= 1'b0;
      dout_q       <= 16'h0000;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      x_q          <= x_d;
      y_q          <= y_d;
      bar_px_q     <= bar_px_d;
      bar_idx_q    <= bar_idx_d;
      grad_b_q     <= grad_b_d;
      bx_q         <= bx_d;
      by_q         <= by_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      data_en_q    <= data_en_d;
      dout_q       <= dout_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign data_en    = data_en_q;
  assign dout       = dout_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: doc/pattern_frame_gen.md
Name: pattern_frame_gen

Overview:
Test-pattern source on the memory write side of the SDRAM/VGA framebuffer path. Each start request produces exactly one frame of RGB565 pixels in raster order, one pixel per accepted cycle. The stream feeds the memory arbiter write port: data_en/dout go to mem_wr_req/mem_din, and wr_en comes from the arbiter's ready-to-write flag. The pattern is selectable per frame and includes a bouncing box, so frame-to-frame SDRAM/display tearing is visible on screen.

Parameters:
H_ACTIVE, 1024, pixels per line; multiple of 8, at least 16.
V_ACTIVE, 768, lines per frame; at least 2.
BOX_SIZE, 64, moving-box edge in pixels; must be less than H_ACTIVE and less than V_ACTIVE.
BOX_STEP, 4, box displacement per frame on each axis; must be less than or equal to BOX_SIZE.

Ports:
clk  input  1  pixel-generation clock (clk_50m domain).
rst_n  input  1  asynchronous reset, active low.
start_i  input  1  single-cycle pulse requesting a new frame.
mode_i  input  2  pattern select; sampled on the accepted start_i.
wr_en  input  1  downstream ready; a pixel is emitted only in cycles where this is high.
data_en  output  1  dout valid; high for exactly one cycle per pixel.
dout  output  16  RGB565 pixel: [15:11] R, [10:5] G, [4:0] B.
busy  output  1  high while a frame is in progress.
frame_done  output  1  one-cycle pulse after the last pixel of a frame.
frame_cnt  output  8  count of completed frames; wraps from 255 to 0.

Behaviour:
Interface:
- One clock (clk). rst_n is asynchronous and active low.
- All outputs are registered.

Reset values:
- data_en=0, dout=0, busy=0, frame_done=0, frame_cnt=0.
- State IDLE, x=0, y=0.
- Box position bx=0, by=0; box direction dx=+1, dy=+1.

State machine (IDLE, RUN, DONE):
- IDLE: on start_i=1, latch mode_i, clear x and y, set busy=1 on the next cycle, go to RUN. While start_i=0, remain in IDLE.
- RUN:
  - Each cycle with wr_en=1: on the next edge, data_en<=1 and dout<=pix(mode,x,y). Then advance x; when x=H_ACTIVE-1, set x=0 and y=y+1.
  - Each cycle with wr_en=0: data_en<=0, dout holds, counters hold.
  - Latency is 1 cycle from wr_en to data_en.
  - After the pixel at (H_ACTIVE-1, V_ACTIVE-1) is issued, go to DONE.
- DONE (one cycle):
  - frame_done<=1, busy<=0, frame_cnt<=frame_cnt+1.
  - Update box: on each axis, if position+step would exceed (size-BOX_SIZE), reverse that direction and move by -BOX_STEP; if position-step would go below 0, reverse and move by +BOX_STEP; otherwise move along the current direction.
  - Go to IDLE.
- start_i while in RUN or DONE is ignored; it is not queued.
- A start_i in the cycle right after DONE (i.e. in IDLE) is accepted.
- Exactly H_ACTIVE*V_ACTIVE data_en pulses occur per frame.

Patterns pix(mode,x,y):
- Mode 0, 8 vertical bars, each H_ACTIVE/8 pixels wide, left to right: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000. Bar index comes from a bar counter that increments every H_ACTIVE/8 pixels and resets at line start. No divider.
- Mode 1, checkerboard of 32x32 squares: FFFF when x[5] XOR y[5] is 0, else 0000.
- Mode 2, gradient: R=x[7:3], G=y[7:2], B=frame_cnt[4:0], using frame_cnt as latched at frame start.
- Mode 3, moving box: FFFF when bx ≤ x < bx+BOX_SIZE and by ≤ y < by+BOX_SIZE, else 001F. bx/by are constant for the whole frame.

Width rules:
- x and y are sized with clog2 of H_ACTIVE and V_ACTIVE.
- Box comparisons are made one bit wider so they cannot overflow.

Reset in mid-operation:
- Asserting rst_n low returns the block to its reset values immediately, including mid-frame.
- No partial-frame frame_done is produced.

Test Plan:
- Reset mid-frame: with H_ACTIVE=16 and V_ACTIVE=4, assert rst_n=0 after 20 pixels → outputs immediately equal the reset values; after release with no start_i, data_en stays 0 for 100 cycles.
- Colour bars with stalls: mode 0, start_i, wr_en toggled 1/0 each cycle → exactly 64 data_en pulses; the first line reads FFFF,FFFF,FFE0,FFE0,…,0000,0000; frame_done pulses once, 1 cycle after the last pixel; frame_cnt=1; busy low afterwards.
- Checkerboard: H_ACTIVE=64, V_ACTIVE=64, mode 1, wr_en held 1 → pixels at (0,0)=FFFF, (32,0)=0000, (32,32)=FFFF; first data_en exactly 1 cycle after the first wr_en in RUN.
- Start handling: start_i pulsed mid-frame → ignored, pixel count unchanged; start_i in the first IDLE cycle after DONE → second frame starts; frame_cnt=2 after it completes.
- Moving box: H_ACTIVE=16, V_ACTIVE=16, BOX_SIZE=4, BOX_STEP=4, mode 3 → frame 0 has the box at (0..3,0..3) and pixel (4,0)=001F; bx sequence over frames is 0,4,8,12,8,4.
- Gradient with counter wrap: mode 2, run 256 frames → frame_cnt wraps to 0; on frame 3, pixel (8,4)=0x0823.
